neural_stage_back: RTL and testbench
====================================

# neural_stage_back

Backward-pass (error back-propagation) stage that mirrors `neural_stage`. It accepts one output-side error term (delta) per cycle, serially over neurons j, with `first` marking j=0. It accumulates in N parallel lanes the transposed weighted sum err_i = sum_j delta_j * w_ji. On frame completion it parallel-loads the N sums into a shift line and streams them serially to the previous layer, while the next frame is already accumulating.

## Interface
- N, 16: number of lanes, which is also the nominal frame length; the taps vector carries N weights.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- first  in  1  the current delta is j=0 of a new frame; the previous frame (if any) is complete.
- flush  in  1  closes the current frame without starting a new one.
- delta_in  in  float_24_8  error term delta_j; sampled every cycle.
- taps  in  neural_stage_tap_typ_16  taps.v_i = w_ji for the current j; sampled every cycle.
- error_out  out  float_24_8  serial back-propagated error err_i, emitted in order i=0..N-1.
- error_out_valid  out  1  error_out holds a valid sum.
- error_out_first  out  1  error_out holds err_0 (first sample of a burst).

## Operation
- float_24_8 is the IEEE-754 single layout: 1 sign, 8 exponent (bias 127), 23 fraction.
  - Product then sum, each rounded to nearest-even.
  - Denormals flush to zero. No fused MAC.
  - Lane arithmetic uses the codebase float multiply/add units, combinational into a registered accumulator.
- Lane i, each cycle t: acc_i(t+1) = (first(t) ? +0.0 : acc_i(t)) + delta_in(t)*taps.v_i(t).
  - All lanes update every cycle.
  - delta=0 contributes nothing (acc unchanged apart from -0 handling).
- started flag:
  - set by first.
  - cleared by flush (when first=0) and by reset.
  - Accumulation occurs regardless of started; only loads depend on it.
- Load event at cycle t: (first(t) or flush(t)) and started(t)=1.
  - Effect: line_i <= acc_i(t), the pre-restart sums, including the delta of cycle t-1 and excluding delta(t).
  - Note: on a flush cycle, delta(t) is still accumulated into a frame that is no longer output; the source must drive delta=0 with flush.
- first and flush in the same cycle: first dominates (load plus restart, started stays 1).
- flush with started=0, or first with started=0: no load.
- Output shift line:
  - After a load, error_out = line_0 and the line shifts toward index 0 each cycle: line_i <= line_{i+1}, line_{N-1} <= 0.
  - A down-counter tracks N cycles of valid output.
- A new load during an unfinished burst (frame shorter than N cycles) discards the remaining old samples and restarts the burst at err_0.
- Frame length is not checked. Sums cover all deltas between consecutive first/flush events.

## Timing
- Reset values:
  - error_out = 0x00000000; error_out_valid = 0; error_out_first = 0.
  - All acc_i, line_i = 0; started = 0; counter = 0.
- Reset mid-burst: outputs drop to reset values on the next edge; the in-flight burst is lost.
- Load at cycle t:
  - error_out_valid = 1 on cycles t+1..t+N.
  - error_out = err_k at cycle t+1+k.
  - error_out_first = 1 only at t+1.
- error_out_valid falls at t+N+1 unless another load occurred. error_out is 0 when not valid.
- Sustained back-to-back N-cycle frames give gapless output: valid stays high, and first pulses every N cycles.
- Latency from the last delta of a frame (cycle t-1) to err_0 is 2 cycles.

## Test plan
- Reset, then 16 cycles of delta=1.0 (0x3F800000) with taps.v_i=float(i), first on cycle 0, then first on cycle 16 -> cycles 17..32 output 0.0, 16.0, 32.0, …, 240.0 (err_15=0x43700000); error_out_first only at 17; valid low at 33.
- Back-to-back frames: frame B uses delta=-0.5, taps.v_i=2.0 -> burst A immediately followed by sixteen -16.0 (0xC1800000) values; valid continuously high; first pulses 16 apart.
- Short frame: 4 deltas of 1.0 with taps.v_i=1.0, then first -> 16 outputs of 4.0. A second first 5 cycles later truncates the burst at 5 samples and restarts at err_0.
- flush after 16 deltas with delta=0 in the flush cycle -> one burst emitted. A second flush with started=0 -> no output.
- reset asserted at burst sample 7 -> valid/first/error_out = 0 next cycle. A subsequent first with no prior frame -> no burst.
- Rounding: delta=1.0, taps.v_0=2^-24, accumulated 2 cycles on top of a 1.0 seed -> err_0 = 1.0 exactly (ties-to-even); denormal product -> contributes 0.

Source files
------------

// File: rtl/neural_stage_back.sv
// Backward-pass stage: N lanes accumulate err_i = sum_j delta_j * w_ji per frame,
// then the finished sums are parallel-loaded into a shift line and streamed out serially.
module neural_stage_back #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 first,
    input  logic                 flush,
    input  logic [31:0]          delta_in,
    input  logic [N-1:0][31:0]   taps,
    output logic [31:0]          error_out,
    output logic                 error_out_valid,
    output logic                 error_out_first
);

    localparam int CW = $clog2(N + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Single-precision multiply, round-to-nearest-even, denormal inputs/results flushed to zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [7:0]         ea, eb;
        logic [47:0]        p;
        logic [23:0]        m;
        logic [24:0]        mr;
        logic               g, st, rnd;
        logic signed [10:0] e;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0))
            return QNAN;
        if (ea == 8'hFF || eb == 8'hFF) begin
            if (ea == 8'd0 || eb == 8'd0)
                return QNAN;
            return {s, 8'hFF, 23'd0};
        end
        if (ea == 8'd0 || eb == 8'd0)
            return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = signed'({3'b000, ea}) + signed'({3'b000, eb}) - 11'sd127;
        if (p[47]) begin
            m  = p[47:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 11'sd1;
        end else begin
            m  = p[46:23];
            g  = p[22];
            st = |p[21:0];
        end
        rnd = g & (st | m[0]);
        mr  = {1'b0, m} + {24'd0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 11'sd1;
        end
        if (e >= 11'sd255)
            return {s, 8'hFF, 23'd0};
        if (e <= 11'sd0)
            return {s, 31'd0};
        return {s, e[7:0], mr[22:0]};
    endfunction

    // Single-precision add with guard/round/sticky, round-to-nearest-even, flush-to-zero.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x, y, big, sml;
        logic [26:0]        mb, ms, msh, mask;
        logic [27:0]        sum;
        logic [7:0]         d;
        logic [23:0]        m;
        logic [24:0]        mr;
        logic               g, rs, rnd;
        logic signed [10:0] e;
        x = (a[30:23] == 8'd0) ? {a[31], 31'd0} : a;
        y = (b[30:23] == 8'd0) ? {b[31], 31'd0} : b;
        if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0))
            return QNAN;
        if (x[30:23] == 8'hFF) begin
            if (y[30:23] == 8'hFF && x[31] != y[31])
                return QNAN;
            return x;
        end
        if (y[30:23] == 8'hFF)
            return y;
        if (x[30:0] == 31'd0 && y[30:0] == 31'd0)
            return {x[31] & y[31], 31'd0};
        if (x[30:0] == 31'd0)
            return y;
        if (y[30:0] == 31'd0)
            return x;
        if (x[30:0] >= y[30:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        mb = {1'b1, big[22:0], 3'b000};
        ms = {1'b1, sml[22:0], 3'b000};
        d  = big[30:23] - sml[30:23];
        if (d >= 8'd27) begin
            msh = 27'd1;
        end else begin
            mask = (27'd1 << d) - 27'd1;
            msh  = ms >> d;
            if ((ms & mask) != 27'd0)
                msh[0] = 1'b1;
        end
        e = signed'({3'b000, big[30:23]});
        if (big[31] == sml[31]) begin
            sum = {1'b0, mb} + {1'b0, msh};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e   = e + 11'sd1;
            end
        end else begin
            sum = {1'b0, mb - msh};
            if (sum == 28'd0)
                return 32'd0;
            // Cancellation can leave leading zeros; renormalise to bit 26.
            for (int k = 0; k < 26; k++) begin
                if (!sum[26]) begin
                    sum = sum << 1;
                    e   = e - 11'sd1;
                end
            end
        end
        m   = sum[26:3];
        g   = sum[2];
        rs  = sum[1] | sum[0];
        rnd = g & (rs | m[0]);
        mr  = {1'b0, m} + {24'd0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 11'sd1;
        end
        if (e >= 11'sd255)
            return {big[31], 8'hFF, 23'd0};
        if (e <= 11'sd0)
            return {big[31], 31'd0};
        return {big[31], e[7:0], mr[22:0]};
    endfunction

    logic [N-1:0][31:0] acc;
    logic [N-1:0][31:0] acc_next;
    logic [N-1:0][31:0] line;
    logic               started;
    logic [CW-1:0]      count;
    logic               burst_first;
    logic               load;

    assign load = (first | flush) & started;

    always_comb begin
        acc_next = '0;
        for (int i = 0; i < N; i++)
            acc_next[i] = fp_add(first ? 32'h0000_0000 : acc[i], fp_mul(delta_in, taps[i]));
    end

    // A load captures the pre-restart sums and restarts the burst even if one is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            line        <= '0;
            started     <= 1'b0;
            count       <= '0;
            burst_first <= 1'b0;
        end else begin
            acc <= acc_next;
            if (first)
                started <= 1'b1;
            else if (flush)
                started <= 1'b0;
            if (load) begin
                line        <= acc;
                count       <= CW'(N);
                burst_first <= 1'b1;
            end else begin
                line        <= {32'h0000_0000, line[N-1:1]};
                burst_first <= 1'b0;
                if (count != '0)
                    count <= count - 1'b1;
            end
        end
    end

    assign error_out_valid = (count != '0);
    assign error_out       = error_out_valid ? line[0] : 32'h0000_0000;
    assign error_out_first = burst_first;

endmodule

// File: tb/tb_neural_stage_back.sv
// Directed self-checking bench for neural_stage_back: burst timing, back-to-back frames,
// truncation, flush, mid-burst reset and float rounding corner cases.
module tb_neural_stage_back;

    localparam int N = 16;
    localparam logic [31:0] F_ONE   = 32'h3F80_0000;
    localparam logic [31:0] F_TWO   = 32'h4000_0000;
    localparam logic [31:0] F_MHALF = 32'hBF00_0000;
    localparam logic [31:0] F_HALF  = 32'h3F00_0000;

    logic               clk = 1'b0;
    logic               reset;
    logic               first;
    logic               flush;
    logic [31:0]        delta_in;
    logic [N-1:0][31:0] taps;
    logic [31:0]        error_out;
    logic               error_out_valid;
    logic               error_out_first;

    logic [N-1:0][31:0] tap_vec;
    int                 total_checks = 0;
    int                 passed_checks = 0;

    neural_stage_back #(.N(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .first           (first),
        .flush           (flush),
        .delta_in        (delta_in),
        .taps            (taps),
        .error_out       (error_out),
        .error_out_valid (error_out_valid),
        .error_out_first (error_out_first)
    );

    always #5 clk = ~clk;

    // Exact float encoding of a small non-negative integer.
    function automatic logic [31:0] itof(input int v);
        int p;
        int frac;
        if (v == 0)
            return 32'h0000_0000;
        p = 0;
        for (int k = 0; k < 31; k++)
            if ((v >> k) != 0)
                p = k;
        frac = (v << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + p), 23'(frac)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        else
            passed_checks++;
    endtask

    task automatic applyStimulus(input logic f, input logic fl, input logic [31:0] d);
        first    = f;
        flush    = fl;
        delta_in = d;
        taps     = tap_vec;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        reset    = 1'b1;
        first    = 1'b0;
        flush    = 1'b0;
        delta_in = 32'h0;
        taps     = '0;
        tap_vec  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic setTaps(input logic [31:0] v);
        for (int i = 0; i < N; i++)
            tap_vec[i] = v;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, error_out_valid}, 32'd0);
        checkOutput({tag, "_out"}, error_out, 32'd0);
    endtask

    initial begin
        // Basic frame: delta 1.0, tap_i = i, load at cycle 16.
        resetDut();
        checkOutput("rst_out", error_out, 32'd0);
        checkOutput("rst_valid", {31'd0, error_out_valid}, 32'd0);
        checkOutput("rst_first", {31'd0, error_out_first}, 32'd0);
        for (int i = 0; i < N; i++)
            tap_vec[i] = itof(i);
        for (int c = 0; c < 16; c++)
            applyStimulus(c == 0, 1'b0, F_ONE);
        checkIdle("t1_pre");
        setTaps(32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 16; k++) begin
            checkOutput("t1_out", error_out, itof(16 * k));
            checkOutput("t1_valid", {31'd0, error_out_valid}, 32'd1);
            checkOutput("t1_first", {31'd0, error_out_first}, {31'd0, k == 0});
            if (k == 15)
                checkOutput("t1_err15", error_out, 32'h4370_0000);
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkIdle("t1_end");
        checkOutput("t1_end_first", {31'd0, error_out_first}, 32'd0);

        // Back-to-back frames: A as above, B = 16 x (-0.5 * 2.0).
        resetDut();
        for (int i = 0; i < N; i++)
            tap_vec[i] = itof(i);
        for (int c = 0; c < 16; c++)
            applyStimulus(c == 0, 1'b0, F_ONE);
        setTaps(F_TWO);
        applyStimulus(1'b1, 1'b0, F_MHALF);
        for (int c = 17; c <= 48; c++) begin
            if (c <= 32)
                checkOutput("t2_a_out", error_out, itof(16 * (c - 17)));
            else
                checkOutput("t2_b_out", error_out, 32'hC180_0000);
            checkOutput("t2_valid", {31'd0, error_out_valid}, 32'd1);
            checkOutput("t2_first", {31'd0, error_out_first}, {31'd0, (c == 17) || (c == 33)});
            if (c <= 31) begin
                applyStimulus(1'b0, 1'b0, F_MHALF);
            end else if (c == 32) begin
                setTaps(32'h0);
                applyStimulus(1'b1, 1'b0, 32'h0);
            end else begin
                applyStimulus(1'b0, 1'b0, 32'h0);
            end
        end
        checkIdle("t2_end");

        // Short frames: 4 ones then 5 ones; the second load truncates the first burst.
        resetDut();
        setTaps(F_ONE);
        for (int c = 0; c < 9; c++)
            applyStimulus((c == 0) || (c == 4), 1'b0, F_ONE);
        setTaps(32'h0);
        for (int c = 9; c <= 25; c++) begin
            if (c >= 10) begin
                checkOutput("t3_second_out", error_out, 32'h40A0_0000);
                checkOutput("t3_second_first", {31'd0, error_out_first}, {31'd0, c == 10});
            end else begin
                checkOutput("t3_first_out", error_out, 32'h4080_0000);
                checkOutput("t3_first_first", {31'd0, error_out_first}, {31'd0, c == 5});
            end
            checkOutput("t3_valid", {31'd0, error_out_valid}, {31'd0, c >= 5});
            applyStimulus(c == 9, 1'b0, 32'h0);
        end
        checkIdle("t3_end");

        // Flush closes the frame; a second flush with nothing started does nothing.
        resetDut();
        setTaps(F_ONE);
        for (int c = 0; c < 16; c++)
            applyStimulus(c == 0, 1'b0, F_ONE);
        setTaps(32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0);
        for (int c = 17; c <= 32; c++) begin
            checkOutput("t4_out", error_out, 32'h4180_0000);
            checkOutput("t4_first", {31'd0, error_out_first}, {31'd0, c == 17});
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkIdle("t4_after");
        applyStimulus(1'b0, 1'b1, 32'h0);
        for (int c = 34; c < 38; c++) begin
            checkIdle("t4_flush2");
            applyStimulus(1'b0, 1'b0, 32'h0);
        end

        // Reset at burst sample 7, then a lone first must not produce a burst.
        resetDut();
        setTaps(F_ONE);
        for (int c = 0; c < 16; c++)
            applyStimulus(c == 0, 1'b0, F_ONE);
        setTaps(32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int c = 17; c < 24; c++)
            applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t5_s7_out", error_out, 32'h4180_0000);
        checkOutput("t5_s7_valid", {31'd0, error_out_valid}, 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        checkIdle("t5_rst");
        checkOutput("t5_rst_first", {31'd0, error_out_first}, 32'd0);
        setTaps(F_ONE);
        applyStimulus(1'b1, 1'b0, F_ONE);
        setTaps(32'h0);
        for (int c = 0; c < 4; c++) begin
            checkIdle("t5_nofr");
            applyStimulus(1'b0, 1'b0, 32'h0);
        end

        // Rounding: ties-to-even, round-up above half, signed sums, denormal product flush.
        resetDut();
        tap_vec[0] = F_ONE;
        tap_vec[2] = F_ONE;
        tap_vec[3] = F_ONE;
        tap_vec[4] = 32'h4040_0000;
        applyStimulus(1'b1, 1'b0, F_ONE);
        setTaps(32'h0);
        tap_vec[0] = 32'h3380_0000;
        tap_vec[2] = 32'h3440_0000;
        tap_vec[3] = 32'h33C0_0000;
        tap_vec[4] = 32'hBF80_0000;
        applyStimulus(1'b0, 1'b0, F_ONE);
        setTaps(32'h0);
        tap_vec[0] = 32'h3380_0000;
        tap_vec[4] = F_HALF;
        applyStimulus(1'b0, 1'b0, F_ONE);
        setTaps(32'h0);
        tap_vec[1] = 32'h0080_0000;
        applyStimulus(1'b0, 1'b0, F_HALF);
        setTaps(32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t6_tie_even", error_out, F_ONE);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t6_denorm", error_out, 32'h0000_0000);
        checkOutput("t6_denorm_valid", {31'd0, error_out_valid}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t6_tie_up", error_out, 32'h3F80_0002);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t6_above_half", error_out, 32'h3F80_0001);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t6_signed", error_out, 32'h4020_0000);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
